// File: rtl/hazard_ctrl_pkg.sv
// Shared MIPS decode constants and hazard-unit FSM state type.
// The opcode/funct values and FSM encodings are kept here so the forwarding unit can share them.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic {
        ST_IDLE,
        ST_MDU_BUSY
    } mdu_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational register-usage decode of an IF/ID instruction.
// Shared between the hazard unit and the forwarding unit.
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic        o_uses_rs,
    output logic        o_uses_rt,
    output logic        o_is_md,
    output logic        o_is_div,
    output logic        o_is_hilo
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_rtype;
    logic       w_shift_imm;
    logic       w_unused_bits;

    assign w_op          = i_instr[31:26];
    assign w_funct       = i_instr[5:0];
    assign o_rs          = i_instr[25:21];
    assign o_rt          = i_instr[20:16];
    assign w_unused_bits = ^i_instr[15:6];

    assign w_rtype     = (w_op == OP_RTYPE);
    assign w_shift_imm = w_rtype && ((w_funct == FN_SLL) || (w_funct == FN_SRL) ||
                                     (w_funct == FN_SRA));

    assign o_uses_rs = !((w_op == OP_J) || (w_op == OP_JAL) || (w_op == OP_LUI) || w_shift_imm);
    assign o_uses_rt = w_rtype || (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_SW);

    assign o_is_md   = w_rtype && ((w_funct == FN_MULT) || (w_funct == FN_MULTU) ||
                                   (w_funct == FN_DIV)  || (w_funct == FN_DIVU));
    assign o_is_div  = w_rtype && ((w_funct == FN_DIV) || (w_funct == FN_DIVU));
    assign o_is_hilo = w_rtype && ((w_funct == FN_MFHI) || (w_funct == FN_MTHI) ||
                                   (w_funct == FN_MFLO) || (w_funct == FN_MTLO));

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard unit: load-use and HI/LO stalls, taken-branch flush, and
// tracking of the multicycle mult/div unit with a small FSM plus down-counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_branch_tkn,
    output logic        hazard,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        mdu_start,
    output logic        mdu_busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_uses_rs;
    logic             w_uses_rt;
    logic             w_is_md;
    logic             w_is_div;
    logic             w_is_hilo;
    logic             w_load_use;
    logic             w_mdu_hz;

    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    hazard_decode u_decode (
        .i_instr   (id_instr),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt),
        .o_is_md   (w_is_md),
        .o_is_div  (w_is_div),
        .o_is_hilo (w_is_hilo)
    );

    // $0 is never a real load destination, so it can never create a dependency.
    assign w_load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                        ((w_uses_rs && (w_rs == id_ex_rt)) ||
                         (w_uses_rt && (w_rt == id_ex_rt)));

    assign w_mdu_hz = mdu_busy && (w_is_md || w_is_hilo);
    assign mdu_busy = (r_state == ST_MDU_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        hazard       = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        mdu_start    = 1'b0;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;

        // Flush outranks every stall so a wrong-path mult/div is never issued.
        if (!reset) begin
            if (ex_branch_tkn) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_load_use || w_mdu_hz) begin
                hazard       = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                mdu_start    = w_is_md;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (mdu_start) begin
                    w_state_nxt = ST_MDU_BUSY;
                    w_cnt_nxt   = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_MDU_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle MDU
// sequences and randomized traffic against a cycle-indexed reference model.
module tb_hazard_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rt;
    logic        ex_branch_tkn;
    logic        hazard;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        mdu_start;
    logic        mdu_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_end = -1;   // model: MDU busy in every cycle index <= busy_end

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_instr      (id_instr),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .ex_branch_tkn (ex_branch_tkn),
        .hazard        (hazard),
        .id_ex_bubble  (id_ex_bubble),
        .if_id_flush   (if_id_flush),
        .mdu_start     (mdu_start),
        .mdu_busy      (mdu_busy)
    );

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  lrt;
        logic        br;
        logic        h;
        logic        b;
        logic        f;
        logic        s;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic void ref_out(input logic [31:0] ins, input logic mr, input logic [4:0] lrt,
                                    input logic br, input logic rst, input logic busy,
                                    output logic h, output logic b, output logic f,
                                    output logic s);
        logic [5:0] op;
        logic [5:0] fn;
        logic       r, u_rs, u_rt, md, hilo, lu;
        op   = ins[31:26];
        fn   = ins[5:0];
        r    = (op == 6'h00);
        u_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F ||
                 (r && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)));
        u_rt = r || op == 6'h04 || op == 6'h05 || op == 6'h2B;
        md   = r && fn >= 6'h18 && fn <= 6'h1B;
        hilo = r && fn >= 6'h10 && fn <= 6'h13;
        lu   = mr && lrt != 0 && ((u_rs && ins[25:21] == lrt) || (u_rt && ins[20:16] == lrt));
        {h, b, f, s} = 4'b0000;
        if (rst)                      {h, b, f, s} = 4'b0000;
        else if (br)                  {h, b, f, s} = 4'b0110;
        else if (lu || (busy && (md || hilo))) {h, b, f, s} = 4'b1100;
        else                          {h, b, f, s} = {3'b000, md};
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic mr, input logic [4:0] lrt,
                        input logic br, input logic rst,
                        output logic ah, output logic ab, output logic af, output logic as);
        logic eh, eb, ef, es, ebusy;
        @(negedge clk);
        id_instr = ins; id_ex_memread = mr; id_ex_rt = lrt; ex_branch_tkn = br; reset = rst;
        #1;
        ebusy = (cyc <= busy_end);
        ref_out(ins, mr, lrt, br, rst, ebusy, eh, eb, ef, es);
        chk("hazard", hazard, eh);
        chk("id_ex_bubble", id_ex_bubble, eb);
        chk("if_id_flush", if_id_flush, ef);
        chk("mdu_start", mdu_start, es);
        chk("mdu_busy", mdu_busy, ebusy);
        ah = hazard; ab = id_ex_bubble; af = if_id_flush; as = mdu_start;
        if (rst)
            busy_end = cyc;
        else if (es)
            busy_end = cyc + ((ins[5:0] == 6'h1A || ins[5:0] == 6'h1B) ? DIV_N : MULT_N);
        cyc++;
    endtask

    initial begin
        logic        h, b, f, s;
        logic [31:0] ins;
        logic [31:0] add98;
        logic [31:0] mult12;
        logic [31:0] div12;
        logic [31:0] mflo;
        logic [31:0] mfhi;
        int          n, starts;

        add98  = r_ins(8, 2, 9, 6'h20);
        mult12 = r_ins(1, 2, 0, 6'h18);
        div12  = r_ins(1, 2, 0, 6'h1A);
        mflo   = r_ins(0, 0, 3, 6'h12);
        mfhi   = r_ins(0, 0, 3, 6'h10);

        vecs[0]  = '{add98, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{add98, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{i_ins(6'h0F, 8, 8, 16'h1234), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{i_ins(6'h2B, 1, 8, 16'h0004), 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{i_ins(6'h08, 1, 8, 16'h0004), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{r_ins(8, 1, 4, 6'h00), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{i_ins(6'h04, 1, 8, 16'hFFFF), 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{i_ins(6'h02, 8, 8, 16'h0000), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{mult12, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{mult12, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{add98, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{mfhi, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{r_ins(8, 0, 0, 6'h08), 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; id_instr = '0; id_ex_memread = 1'b0; id_ex_rt = '0; ex_branch_tkn = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state: stall-worthy inputs are masked while reset is held.
        step(add98, 1'b1, 5'd8, 1'b0, 1'b1, h, b, f, s);
        chk("reset_hazard", h, 1'b0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].instr, vecs[i].mr, vecs[i].lrt, vecs[i].br, 1'b0, h, b, f, s);
            chk($sformatf("tbl%0d_hazard", i), h, vecs[i].h);
            chk($sformatf("tbl%0d_bubble", i), b, vecs[i].b);
            chk($sformatf("tbl%0d_flush", i), f, vecs[i].f);
            chk($sformatf("tbl%0d_start", i), s, vecs[i].s);
            step(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, h, b, f, s);
        end

        // Load-use stall lasts one cycle once the bubble clears memread.
        step(add98, 1'b1, 5'd8, 1'b0, 1'b0, h, b, f, s);
        chk("lu_first", h, 1'b1);
        step(add98, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("lu_second", h, 1'b0);

        // mult, then mflo two cycles later stalls until HI/LO are ready.
        step(mult12, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("mult_start", s, 1'b1);
        step(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("mult_busy", mdu_busy, 1'b1);
        n = 0;
        do begin
            step(mflo, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
            if (h) n++;
        end while (h && n < 40);
        chk_int("mflo_stall_cycles", n, 3);
        chk("mflo_busy_low", mdu_busy, 1'b0);

        // Back-to-back divides.
        starts = 0;
        step(div12, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        if (s) starts++;
        n = 0;
        do begin
            step(div12, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
            if (h) n++;
            if (s) starts++;
        end while (h && n < 60);
        chk_int("div_stall_cycles", n, DIV_N);
        chk_int("div_start_pulses", starts, 2);
        chk("div2_issued_idle", mdu_busy, 1'b0);
        step(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("div2_busy", mdu_busy, 1'b1);
        step(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, h, b, f, s);

        // Mult on the wrong path never issues.
        step(mult12, 1'b0, 5'd0, 1'b1, 1'b0, h, b, f, s);
        chk("wrongpath_start", s, 1'b0);
        step(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("wrongpath_busy", mdu_busy, 1'b0);

        // Reset in the middle of a divide (count at 20) abandons it.
        step(div12, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        repeat (12) step(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("middiv_busy", mdu_busy, 1'b1);
        step(mfhi, 1'b0, 5'd0, 1'b0, 1'b1, h, b, f, s);
        step(mfhi, 1'b0, 5'd0, 1'b0, 1'b0, h, b, f, s);
        chk("postreset_busy", mdu_busy, 1'b0);
        chk("postreset_mfhi", h, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rs, rt;
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 10))
                0: ins = r_ins(rs, rt, 5, 6'h20);
                1: ins = r_ins(rs, rt, 0, 6'($urandom_range(24, 25)));
                2: ins = r_ins(rs, rt, 0, 6'($urandom_range(26, 27)));
                3: ins = r_ins(rs, rt, 4, 6'($urandom_range(16, 19)));
                4: ins = i_ins(6'h23, rs, rt, 16'($urandom));
                5: ins = i_ins(6'h2B, rs, rt, 16'($urandom));
                6: ins = i_ins(6'($urandom_range(4, 5)), rs, rt, 16'($urandom));
                7: ins = i_ins(6'h0F, rs, rt, 16'($urandom));
                8: ins = i_ins(6'($urandom_range(2, 3)), rs, rt, 16'($urandom));
                9: ins = r_ins(rs, rt, 6, 6'(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 3)));
                default: ins = $urandom;
            endcase
            step(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), h, b, f, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
